// File: rtl/haze_frame_controller.sv
// Frame sequencer for the two-pass dehaze pipeline: one pass estimates the
// atmospheric light, then the latched constants drive a second, recovery pass.
module haze_frame_controller #(
  parameter int IMG_W        = 512,
  parameter int IMG_H        = 512,
  parameter int ADDR_W       = 18,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              win_valid,
  output logic              ale_clr,
  output logic              ale_valid,
  input  logic              ale_done,
  input  logic [7:0]        ale_a_r,
  input  logic [7:0]        ale_a_g,
  input  logic [7:0]        ale_a_b,
  input  logic [15:0]       ale_inv_r,
  input  logic [15:0]       ale_inv_g,
  input  logic [15:0]       ale_inv_b,
  output logic [7:0]        A_R,
  output logic [7:0]        A_G,
  output logic [7:0]        A_B,
  output logic [15:0]       Inv_A_R,
  output logic [15:0]       Inv_A_G,
  output logic [15:0]       Inv_A_B,
  output logic              params_valid,
  output logic              dehaze_valid,
  output logic              pass_id,
  output logic              busy,
  output logic              frame_done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W:0]   NPIX_CNT  = (ADDR_W + 1)'(NPIX);
  localparam int SW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CLR      = 4'd1;
  localparam logic [3:0] S_EST      = 4'd2;
  localparam logic [3:0] S_EST_WAIT = 4'd3;
  localparam logic [3:0] S_SETTLE   = 4'd4;
  localparam logic [3:0] S_LATCH    = 4'd5;
  localparam logic [3:0] S_RCV      = 4'd6;
  localparam logic [3:0] S_RCV_WAIT = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   win_cnt_q, win_cnt_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              done_seen_q, done_seen_d;
  logic              pv_q, pv_d;
  logic [71:0]       cst_q, cst_d;

  assign rd_en        = ((state_q == S_EST) || (state_q == S_RCV)) && !stall;
  assign rd_addr      = addr_q;
  assign ale_clr      = (state_q == S_CLR);
  assign ale_valid    = win_valid && ((state_q == S_EST) || (state_q == S_EST_WAIT));
  assign dehaze_valid = win_valid && ((state_q == S_RCV) || (state_q == S_RCV_WAIT));
  assign pass_id      = (state_q == S_LATCH) || (state_q == S_RCV) ||
                        (state_q == S_RCV_WAIT) || (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = (state_q == S_DONE);
  assign params_valid = pv_q;
  assign {A_R, A_G, A_B, Inv_A_R, Inv_A_G, Inv_A_B} = cst_q;

  // Next-state, address and counter logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    win_cnt_d   = win_cnt_q;
    settle_d    = settle_q;
    done_seen_d = done_seen_q;
    pv_d        = pv_q;
    cst_d       = cst_q;

    if (rd_en) begin
      if (addr_q == LAST_ADDR) begin
        addr_d = {ADDR_W{1'b0}};
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end else begin
      addr_d = addr_q;
    end

    // Saturating so a stray extra window cannot wrap past the frame size
    if (dehaze_valid && (win_cnt_q != NPIX_CNT)) begin
      win_cnt_d = win_cnt_q + (ADDR_W + 1)'(1);
    end else begin
      win_cnt_d = win_cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          pv_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR: begin
        addr_d      = {ADDR_W{1'b0}};
        win_cnt_d   = {(ADDR_W + 1){1'b0}};
        done_seen_d = 1'b0;
        state_d     = S_EST;
      end
      S_EST: begin
        // An early done must survive until the read pass finishes
        if (ale_done) begin
          done_seen_d = 1'b1;
        end else begin
          done_seen_d = done_seen_q;
        end
        if (rd_en && (addr_q == LAST_ADDR)) begin
          state_d = S_EST_WAIT;
        end else begin
          state_d = S_EST;
        end
      end
      S_EST_WAIT: begin
        if (ale_done || done_seen_q) begin
          settle_d = {SW{1'b0}};
          if (DRAIN_CYCLES == 0) begin
            state_d = S_LATCH;
          end else begin
            state_d = S_SETTLE;
          end
        end else begin
          state_d = S_EST_WAIT;
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_LATCH;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_LATCH: begin
        cst_d   = {ale_a_r, ale_a_g, ale_a_b, ale_inv_r, ale_inv_g, ale_inv_b};
        pv_d    = 1'b1;
        state_d = S_RCV;
      end
      S_RCV: begin
        if (rd_en && (addr_q == LAST_ADDR)) begin
          state_d = S_RCV_WAIT;
        end else begin
          state_d = S_RCV;
        end
      end
      S_RCV_WAIT: begin
        if (win_cnt_q == NPIX_CNT) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RCV_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; rst is synchronous and wins over start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      win_cnt_q   <= {(ADDR_W + 1){1'b0}};
      settle_q    <= {SW{1'b0}};
      done_seen_q <= 1'b0;
      pv_q        <= 1'b0;
      cst_q       <= 72'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      win_cnt_q   <= win_cnt_d;
      settle_q    <= settle_d;
      done_seen_q <= done_seen_d;
      pv_q        <= pv_d;
      cst_q       <= cst_d;
    end
  end

endmodule

// File: tb/tb_haze_frame_controller.sv
// Scoreboard bench: expectations are queued when a frame is started and a
// negedge monitor pops them as the controller presents reads, clears and done.
module tb_haze_frame_controller;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 4;
  localparam int DR = 2;
  localparam int N  = W * H;

  logic clk = 1'b0;
  logic rst, start, stall, win_valid, ale_done;
  logic [7:0]  ale_a_r, ale_a_g, ale_a_b;
  logic [15:0] ale_inv_r, ale_inv_g, ale_inv_b;
  logic rd_en, ale_clr, ale_valid, params_valid, dehaze_valid, pass_id, busy, frame_done;
  logic [AW-1:0] rd_addr;
  logic [7:0]  A_R, A_G, A_B;
  logic [15:0] Inv_A_R, Inv_A_G, Inv_A_B;

  haze_frame_controller #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DRAIN_CYCLES(DR)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .rd_en(rd_en), .rd_addr(rd_addr), .win_valid(win_valid),
    .ale_clr(ale_clr), .ale_valid(ale_valid), .ale_done(ale_done),
    .ale_a_r(ale_a_r), .ale_a_g(ale_a_g), .ale_a_b(ale_a_b),
    .ale_inv_r(ale_inv_r), .ale_inv_g(ale_inv_g), .ale_inv_b(ale_inv_b),
    .A_R(A_R), .A_G(A_G), .A_B(A_B),
    .Inv_A_R(Inv_A_R), .Inv_A_G(Inv_A_G), .Inv_A_B(Inv_A_B),
    .params_valid(params_valid), .dehaze_valid(dehaze_valid),
    .pass_id(pass_id), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic pass; logic [AW-1:0] addr; } rd_exp_t;
  typedef struct packed { logic [7:0] r, g, b; logic [15:0] ir, ig, ib; } cst_t;

  rd_exp_t rd_q[$];
  cst_t    clr_q[$];
  cst_t    latch_q[$];
  cst_t    done_q[$];
  int      delta_q[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, last_est = 0, n_done = 0, est_cnt = 0, rcv_cnt = 0;
  bit h1 = 1'b0, h2 = 1'b0, prev_pass = 1'b0, prev_pv = 1'b0, chk_after = 1'b0;
  bit pulse_mode = 1'b0;
  cst_t last_done;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic cst_t cur_cst();
    return {A_R, A_G, A_B, Inv_A_R, Inv_A_G, Inv_A_B};
  endfunction

  // Monitor, scoreboard and bench-side estimator/line-buffer models
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rd_en) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 80'(rd_addr), 80'hFFFF);
      else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        chk("rd_addr", 80'(rd_addr), 80'(e.addr));
        chk("rd_pass", 80'(pass_id), 80'(e.pass));
      end
      if (!pass_id) last_est = cyc;
    end
    if (pass_id && !prev_pass) begin
      if (delta_q.size() == 0) chk("latch_unexpected", 80'(1), 80'(0));
      else chk("latch_delay", 80'(cyc - last_est), 80'(delta_q.pop_front()));
    end
    prev_pass = pass_id;
    if (params_valid && !prev_pv && busy) begin
      if (latch_q.size() == 0) chk("pv_unexpected", 80'(1), 80'(0));
      else chk("latched_consts", 80'(cur_cst()), 80'(latch_q.pop_front()));
    end
    prev_pv = params_valid;
    if (ale_clr) begin
      if (clr_q.size() == 0) chk("clr_unexpected", 80'(1), 80'(0));
      else begin
        chk("clr_held_consts", 80'(cur_cst()), 80'(clr_q.pop_front()));
        chk("clr_pv_cleared", 80'(params_valid), 80'(0));
        chk("clr_busy", 80'(busy), 80'(1));
      end
    end
    if (chk_after) begin
      chk("busy_after_done", 80'(busy), 80'(0));
      chk("consts_after_done", 80'(cur_cst()), 80'(last_done));
      chk("pv_after_done", 80'(params_valid), 80'(1));
      chk_after = 1'b0;
    end
    if (frame_done) begin
      n_done++;
      if (done_q.size() == 0) chk("done_unexpected", 80'(1), 80'(0));
      else begin
        last_done = done_q.pop_front();
        chk("done_consts", 80'(cur_cst()), 80'(last_done));
        chk("done_pv", 80'(params_valid), 80'(1));
        chk("done_rcv_windows", 80'(rcv_cnt), 80'(N));
        chk_after = 1'b1;
      end
    end
    h2 = h1;
    h1 = rd_en;
    if (ale_clr) begin
      est_cnt = 0;
      rcv_cnt = 0;
    end else begin
      if (ale_valid) est_cnt++;
      if (dehaze_valid) rcv_cnt++;
    end
  end

  // Line buffer: window valid two cycles after each read; estimator done
  initial forever begin
    @(posedge clk);
    #1;
    win_valid = h2;
    if (pulse_mode) ale_done = busy && !pass_id && (rd_addr == AW'(N - 1));
    else            ale_done = (est_cnt >= N);
  end

  task automatic check_idle(input string tag);
    chk({tag, "_rd_en"}, 80'(rd_en), 80'(0));
    chk({tag, "_rd_addr"}, 80'(rd_addr), 80'(0));
    chk({tag, "_ale_clr"}, 80'(ale_clr), 80'(0));
    chk({tag, "_ale_valid"}, 80'(ale_valid), 80'(0));
    chk({tag, "_dehaze_valid"}, 80'(dehaze_valid), 80'(0));
    chk({tag, "_pass_id"}, 80'(pass_id), 80'(0));
    chk({tag, "_busy"}, 80'(busy), 80'(0));
    chk({tag, "_frame_done"}, 80'(frame_done), 80'(0));
    chk({tag, "_params_valid"}, 80'(params_valid), 80'(0));
    chk({tag, "_consts"}, 80'(cur_cst()), 80'(0));
  endtask

  task automatic run_frame(input cst_t v, input cst_t prev, input bit do_stall,
                           input bit pulse, input bit extra_start, input bit rst_at9);
    int d0, sc, c;
    bit aborted, did_rst;
    rd_exp_t e;
    @(posedge clk);
    #1;
    pulse_mode = pulse;
    {ale_a_r, ale_a_g, ale_a_b, ale_inv_r, ale_inv_g, ale_inv_b} = v;
    start = 1'b1;
    clr_q.push_back(prev);
    latch_q.push_back(v);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < N; i++) begin
        e.pass = p[0];
        e.addr = AW'(i);
        rd_q.push_back(e);
      end
    end
    delta_q.push_back(pulse ? (2 + DR) : (4 + DR));
    if (!rst_at9) done_q.push_back(v);
    d0 = n_done;
    sc = 0; c = 0; aborted = 1'b0; did_rst = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (n_done == d0 && !aborted && c < 400) begin
      @(posedge clk);
      #1;
      c++;
      if (params_valid) {ale_a_r, ale_a_g, ale_a_b, ale_inv_r, ale_inv_g, ale_inv_b} = ~v;
      if (extra_start && ((busy && !pass_id && rd_addr == AW'(3)) || frame_done)) start = 1'b1;
      else start = 1'b0;
      if (did_rst) begin
        rst = 1'b0;
        rd_q.delete();
        @(negedge clk);
        check_idle("midrst");
        aborted = 1'b1;
      end else if (rst_at9 && busy && pass_id && rd_addr == AW'(9)) begin
        rst = 1'b1;
        did_rst = 1'b1;
      end
      if (do_stall && sc == 0 && busy && !pass_id && rd_addr == AW'(5)) sc = 1;
      if (sc >= 1 && sc <= 3) begin
        stall = 1'b1;
        sc++;
        @(negedge clk);
        chk("stall_rd_en", 80'(rd_en), 80'(0));
        chk("stall_rd_addr", 80'(rd_addr), 80'(5));
      end else begin
        stall = 1'b0;
      end
    end
    start = 1'b0;
    stall = 1'b0;
    if (!aborted) begin
      chk("frame_timeout", 80'(n_done != d0), 80'(1));
      @(negedge clk);
      chk("rd_leftover", 80'(rd_q.size()), 80'(0));
    end
  endtask

  initial begin
    cst_t z, v1, v2, v3, v4, v5;
    z  = '0;
    v1 = {8'd200, 8'd180, 8'd150, 16'h0147, 16'h016C, 16'h01B4};
    v2 = {8'd10,  8'd20,  8'd30,  16'h1999, 16'h0CCC, 16'h0888};
    v3 = {8'd255, 8'd1,   8'd128, 16'h0101, 16'hFFFF, 16'h0200};
    v4 = {8'd7,   8'd8,   8'd9,   16'h2492, 16'h2000, 16'h1C71};
    v5 = {8'd99,  8'd98,  8'd97,  16'h0295, 16'h029C, 16'h02A3};
    rst = 1'b1; start = 1'b1; stall = 1'b0; win_valid = 1'b0; ale_done = 1'b0;
    {ale_a_r, ale_a_g, ale_a_b, ale_inv_r, ale_inv_g, ale_inv_b} = v5;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle("reset");
    @(negedge clk);
    chk("start_during_rst_ignored", 80'(busy), 80'(0));

    run_frame(v1, z,  1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(v2, v1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(v3, v2, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("no_frame_after_ignored_start", 80'(busy), 80'(0));
    run_frame(v4, v3, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(v5, z,  1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("frame_done_count", 80'(n_done), 80'(4));
    chk("clr_queue_empty", 80'(clr_q.size()), 80'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
